// File: rtl/pipelined_ripple_adder_if.sv
// Valid/ready operand and result stream for pipelined_ripple_adder.
// The ovf signal exists only when SIGNED_OVF_EN is defined.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 32
) ();
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;

  // Producer/consumer environment around the adder
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  // Producer/consumer environment around the adder
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit a + b + cin, carry chain cut into
// SEG-bit ripple segments with one register stage per segment.
// One addition accepted per clock; valid/ready backpressure freezes the
// whole pipe. Optional signed-overflow output under macro SIGNED_OVF_EN.
module pipelined_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_ripple_adder_if.slave bus
);

  localparam int STAGES = WIDTH / SEG;

  // A partial last segment would silently drop upper operand bits.
  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_cfg_error
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // One SEG-bit ripple segment built from full-adder cells.
  // Returns {carry_out, sum_segment}.
  function automatic logic [SEG:0] f_seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG-1:0] s;
    logic           c;
    s = '0;
    c = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, s};
  endfunction

  logic w_adv;
  logic w_out_valid;

  // Whole pipe moves together; only a stalled valid result blocks it.
  assign w_adv       = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bit position of the segment this stage adds.
    localparam int LO = k * SEG;

    // Operand bits not yet added, LSB-aligned on this stage's segment.
    logic [WIDTH-LO-1:0] w_a_rem;
    logic [WIDTH-LO-1:0] w_b_rem;
    logic                w_ci;
    logic                w_vin;
    logic [SEG-1:0]      w_x;
    logic [SEG-1:0]      w_y;
    logic [SEG:0]        w_add;
    logic [LO+SEG-1:0]   w_res_next;

    // Stage register: valid, completed result bits, segment carry-out.
    logic                r_vld;
    logic [LO+SEG-1:0]   r_res;
    logic                r_cy;

    if (k == 0) begin : g_head
      assign w_a_rem    = bus.a;
      assign w_b_rem    = bus.b;
      assign w_ci       = bus.cin;
      assign w_vin      = bus.in_valid;
      assign w_res_next = w_add[SEG-1:0];
    end else begin : g_body
      assign w_a_rem    = g_stage[k-1].g_skew.r_a;
      assign w_b_rem    = g_stage[k-1].g_skew.r_b;
      assign w_ci       = g_stage[k-1].r_cy;
      assign w_vin      = g_stage[k-1].r_vld;
      assign w_res_next = {w_add[SEG-1:0], g_stage[k-1].r_res};
    end

    assign w_x   = w_a_rem[SEG-1:0];
    assign w_y   = w_b_rem[SEG-1:0];
    assign w_add = f_seg_add(w_x, w_y, w_ci);

    // Valid bit: cleared by reset so in-flight work is discarded.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vin;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // Output stage data: reset to zero because it drives sum/cout.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_res <= '0;
          r_cy  <= 1'b0;
        end else if (w_adv) begin
          r_res <= w_res_next;
          r_cy  <= w_add[SEG];
        end
      end
    end else begin : g_skew
      // Upper operand segments still waiting for their stage.
      logic [WIDTH-LO-SEG-1:0] r_a;
      logic [WIDTH-LO-SEG-1:0] r_b;

      // Intermediate data: qualified by the valid bit, so no reset needed.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_res <= w_res_next;
          r_cy  <= w_add[SEG];
          r_a   <= w_a_rem[WIDTH-LO-1:SEG];
          r_b   <= w_b_rem[WIDTH-LO-1:SEG];
        end
      end
    end
  end

  assign w_out_valid   = g_stage[STAGES-1].r_vld;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = g_stage[STAGES-1].r_res;
  assign bus.cout      = g_stage[STAGES-1].r_cy;

`ifdef SIGNED_OVF_EN
  logic w_ovf_next;
  logic r_ovf;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign w_ovf_next = (g_stage[STAGES-1].w_x[SEG-1] ^
                       g_stage[STAGES-1].w_y[SEG-1] ^
                       g_stage[STAGES-1].w_add[SEG-1]) ^
                      g_stage[STAGES-1].w_add[SEG];

  // Overflow flag registered alongside the final stage result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder (WIDTH=32, SEG=8, four stages).
module tb_pipelined_ripple_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  pipelined_ripple_adder_if #(.WIDTH(W)) bus ();

  pipelined_ripple_adder #(.WIDTH(W), .SEG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a pipe of whole results, stepped by the advance rule.
  logic        m_vld [S];
  logic [32:0] m_res [S];
  logic        m_ovf [S];
  logic        m_known;
  logic        m_zero;
  int          n_acc;
  int          n_got;

  initial begin
    m_known = 1'b0;
    m_zero  = 1'b0;
    n_acc   = 0;
    n_got   = 0;
    for (int i = 0; i < S; i++) begin
      m_vld[i] = 1'b0;
      m_res[i] = '0;
      m_ovf[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic   adv;
    longint sv;
    if (m_known) begin
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_vld[S-1]});
      if (rst_n)
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, (!m_vld[S-1] || bus.out_ready)});
      if (m_vld[S-1]) begin
        check("sum", {32'd0, bus.sum}, {32'd0, m_res[S-1][31:0]});
        check("cout", {63'd0, bus.cout}, {63'd0, m_res[S-1][32]});
`ifdef SIGNED_OVF_EN
        check("ovf", {63'd0, bus.ovf}, {63'd0, m_ovf[S-1]});
`endif
      end
      if (m_zero) begin
        check("sum_rst", {32'd0, bus.sum}, 64'd0);
        check("cout_rst", {63'd0, bus.cout}, 64'd0);
`ifdef SIGNED_OVF_EN
        check("ovf_rst", {63'd0, bus.ovf}, 64'd0);
`endif
      end
      if (rst_n && bus.out_valid && bus.out_ready) n_got++;
    end
    // Step the reference for the coming rising edge.
    adv = !m_vld[S-1] || bus.out_ready;
    if (!rst_n) begin
      for (int i = 0; i < S; i++) m_vld[i] = 1'b0;
      m_known = 1'b1;
      m_zero  = 1'b1;
    end else if (m_known && adv) begin
      for (int i = S-1; i > 0; i--) begin
        m_vld[i] = m_vld[i-1];
        m_res[i] = m_res[i-1];
        m_ovf[i] = m_ovf[i-1];
      end
      m_vld[0] = bus.in_valid;
      m_res[0] = {1'b0, bus.a} + {1'b0, bus.b} + {32'd0, bus.cin};
      sv = longint'($signed(bus.a)) + longint'($signed(bus.b)) + longint'(bus.cin);
      m_ovf[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      m_zero = 1'b0;
      if (bus.in_valid) n_acc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until the block takes it.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc);
    logic acc;
    int   guard;
    bus.a        = ta;
    bus.b        = tb_;
    bus.cin      = tc;
    bus.in_valid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_accept", 64'd0, 64'd1);
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];

  initial begin
    va[0] = 32'h12345678; vb[0] = 32'h11111111; vc[0] = 1'b1;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 1'b0;
    va[2] = 32'hFFFF0000; vb[2] = 32'h0000FFFF; vc[2] = 1'b1;
    va[3] = 32'h00FF00FF; vb[3] = 32'h00010001; vc[3] = 1'b0;
    va[4] = 32'hDEADBEEF; vb[4] = 32'h01234567; vc[4] = 1'b0;
    va[5] = 32'h7FFFFFFF; vb[5] = 32'h00000001; vc[5] = 1'b0;
    va[6] = 32'h00000000; vb[6] = 32'h00000000; vc[6] = 1'b1;
    va[7] = 32'hAAAAAAAA; vb[7] = 32'h55555555; vc[7] = 1'b1;

    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h5;
    bus.b         = 32'h6;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for two edges with in_valid asserted.
    tick();
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_sum", {32'd0, bus.sum}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();

    // Carry rippling through every segment.
    send(32'hFFFFFFFF, 32'h00000000, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("ripple_early", {63'd0, bus.out_valid}, 64'd0);
    tick();
    check("ripple_valid", {63'd0, bus.out_valid}, 64'd1);
    check("ripple_sum", {32'd0, bus.sum}, 64'h0);
    check("ripple_cout", {63'd0, bus.cout}, 64'd1);
    tick();
    check("ripple_once", {63'd0, bus.out_valid}, 64'd0);
    tick();

    // Back-to-back stream of eight operand sets.
    for (int i = 0; i < 8; i++) begin
      send(va[i], vb[i], vc[i]);
      if (i == 3) check("stream0_sum", {32'd0, bus.sum}, 64'h2345678A);
      if (i == 4) begin
        check("stream1_sum", {32'd0, bus.sum}, 64'h0);
        check("stream1_cout", {63'd0, bus.cout}, 64'd1);
      end
      if (i == 6) check("stream3_sum", {32'd0, bus.sum}, 64'h01000100);
    end
    bus.in_valid = 1'b0;
    repeat (6) tick();

    // Fill the pipe, then stall the consumer for three cycles.
    send(32'h00000001, 32'h00000002, 1'b0);
    send(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    send(32'h00000100, 32'h00000F00, 1'b0);
    bus.out_ready = 1'b0;
    bus.a = 32'h10;
    bus.b = 32'h20;
    bus.cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_sum", {32'd0, bus.sum}, 64'h3);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    send(32'h00000010, 32'h00000020, 1'b0);
    send(32'h00000001, 32'hFFFFFFFF, 1'b0);
    bus.in_valid = 1'b0;
    repeat (8) tick();
    check("no_loss", 64'(n_got), 64'(n_acc));

    // Signed overflow corner cases.
    send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("ovf_a_sum", {32'd0, bus.sum}, 64'h80000000);
    check("ovf_a_cout", {63'd0, bus.cout}, 64'd0);
`ifdef SIGNED_OVF_EN
    check("ovf_a_ovf", {63'd0, bus.ovf}, 64'd1);
`endif
    tick();
    check("ovf_b_sum", {32'd0, bus.sum}, 64'h0);
    check("ovf_b_cout", {63'd0, bus.cout}, 64'd1);
`ifdef SIGNED_OVF_EN
    check("ovf_b_ovf", {63'd0, bus.ovf}, 64'd0);
`endif
    repeat (3) tick();

    // Reset with three operations in flight.
    send(32'h00000011, 32'h00000022, 1'b0);
    send(32'h00000033, 32'h00000044, 1'b0);
    send(32'h00000055, 32'h00000066, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_sum", {32'd0, bus.sum}, 64'd0);
    send(32'h00000100, 32'h00000200, 1'b1);
    bus.in_valid = 1'b0;
    check("mid_rst_q0", {63'd0, bus.out_valid}, 64'd0);
    tick();
    check("mid_rst_q1", {63'd0, bus.out_valid}, 64'd0);
    tick();
    check("mid_rst_q2", {63'd0, bus.out_valid}, 64'd0);
    tick();
    check("mid_rst_new_valid", {63'd0, bus.out_valid}, 64'd1);
    check("mid_rst_new_sum", {32'd0, bus.sum}, 64'h301);
    tick();
    check("mid_rst_drained", {63'd0, bus.out_valid}, 64'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parameterised, pipelined successor to the team's 4-bit ripple-carry adder. Adds two WIDTH-bit operands plus carry-in. The carry chain is split into SEG-bit ripple segments with one register stage per segment, so throughput is one addition per clock at any width. Sits between operand producers and consumers on a valid/ready stream and supports backpressure.

## Interface
- WIDTH, 32, operand and sum width; must be an integer multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG is derived, not set.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands on a/b/cin are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned bit vector.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with SIGNED_OVF_EN.

## Operation
- Stage k (0..STAGES-1) ripples segment k, bits [k*SEG +: SEG], using per-bit full-adder cells: sum = x^y^c, carry = majority(x, y, c).
- Carry into stage 0 is cin. Carry into stage k>0 is the carry registered by stage k-1.
- Each stage register holds:
  - a valid bit;
  - the result segments completed so far;
  - the operand segments not yet added (skew registers);
  - the segment carry-out.
- The last stage register drives sum, cout (and ovf) directly. All outputs are registered; there is no combinational path from inputs to outputs.
- Pipeline advance enable: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts forward one step.
  - When adv=0, every stage holds.
- in_ready = adv. An operand set is accepted when in_valid && in_ready.
- If in_valid is low while adv=1, a bubble (valid bit 0) enters stage 0. Bubbles are not compressed.
- Results leave in acceptance order; none are dropped or duplicated.
- Reset (rst_n low at a clock edge):
  - all valid bits clear; out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 on the first cycle after reset releases;
  - operations in flight are discarded and never appear on the output.
- WIDTH not divisible by SEG is an elaboration-time error.

## Timing
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1. With STAGES=1, the result is visible the cycle after acceptance.
- Throughput: one result per cycle while out_ready=1.
- A result is consumed on an edge where out_valid && out_ready.
- While out_valid && !out_ready:
  - sum, cout and ovf stay stable;
  - in_ready=0;
  - no internal state changes.
- Accept and consume may happen in the same cycle.
- A single-cycle stall only freezes the pipe; data ahead of the stall is never overwritten.
- Critical path: SEG full-adder carry cells plus the register setup time.

## Configuration
- SIGNED_OVF_EN defined:
  - the ovf port exists;
  - ovf = (carry into bit WIDTH-1) XOR cout, registered and aligned with sum;
  - ovf reset value is 0.
- SIGNED_OVF_EN undefined: no ovf port and no extra register bit; behaviour is otherwise identical.

## Test plan
All scenarios use WIDTH=32 and SEG=8, giving latency 4.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0 throughout; in_ready=1 on the first cycle after release.
- Full carry ripple: a=0xFFFFFFFF, b=0, cin=1, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, out_valid high for exactly 1 cycle.
- Streaming: 8 back-to-back random operand sets with out_ready=1 -> 8 consecutive result cycles, in order, each matching a+b+cin against a reference model.
- Backpressure: fill the pipe, drop out_ready for 3 cycles -> sum/cout frozen, in_ready=0, and all results delivered in order after release with no loss or duplication.
- Signed overflow (SIGNED_OVF_EN): a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0.
- Reset mid-stream: pull rst_n low for 1 cycle with 3 operations in flight -> out_valid stays 0 until a newly accepted operation completes 4 cycles after its acceptance.
